// File: rtl/dll_rx_acknak.sv
// Receive-side data-link ACK/NAK engine.
// Classifies each strobed TLP against next_rcv_seq and pulses accept or drop
// one cycle later. ACK/NAK DLLPs are requested towards the link transmitter
// through a valid/ready handshake.
// Optional feature macro: ACK_COALESCE_EN. When defined, ACKs are coalesced
// by a latency timer (ACK_LAT) and a pending-count threshold (ACK_THRESH).
// When undefined, every accepted TLP makes an ACK due at once.
// Ports:
//   clk, reset_n          clock (rising edge), async active-low reset
//   tlp_valid_i           one-cycle strobe: TLP header/status present
//   tlp_seq_i             sequence number of the strobed TLP
//   tlp_crc_ok_i          LCRC check result for the strobed TLP
//   tlp_accept_o          pulse: TLP good and in order
//   tlp_drop_o            pulse: TLP discarded
//   dllp_valid_o          DLLP request to the link transmitter
//   dllp_ready_i          transmitter takes the DLLP when valid & ready
//   dllp_type_o           2'b01 ACK, 2'b10 NAK, 2'b00 idle
//   dllp_seq_o            AckNak_Seq_Num (next_rcv_seq - 1 when latched)
//   nak_scheduled_o       NAK issued, no good in-order TLP since
module dll_rx_acknak #(
  parameter int unsigned SEQ_W      = 12,
  parameter int unsigned ACK_LAT    = 64,
  parameter int unsigned ACK_THRESH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tlp_valid_i,
  input  logic [SEQ_W-1:0] tlp_seq_i,
  input  logic             tlp_crc_ok_i,
  output logic             tlp_accept_o,
  output logic             tlp_drop_o,
  output logic             dllp_valid_o,
  input  logic             dllp_ready_i,
  output logic [1:0]       dllp_type_o,
  output logic [SEQ_W-1:0] dllp_seq_o,
  output logic             nak_scheduled_o
);

  localparam int unsigned CNT_W = $clog2(ACK_THRESH + 1);
  localparam int unsigned TMR_W = $clog2(ACK_LAT);

  localparam logic [SEQ_W-1:0] DUP_WIN  = {1'b1, {(SEQ_W-1){1'b0}}};
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(ACK_THRESH);

  localparam logic [1:0] DLLP_IDLE = 2'b00;
  localparam logic [1:0] DLLP_ACK  = 2'b01;
  localparam logic [1:0] DLLP_NAK  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  state_e           state_q;
  logic [SEQ_W-1:0] nrs_q;        // next_rcv_seq
  logic [CNT_W-1:0] pend_q;       // accepted TLPs not covered by a latched DLLP
  logic [TMR_W-1:0] tmr_q;
  logic             nak_sched_q;
  logic             nak_flag_q;   // NAK requested, not yet latched
  logic             ack_flag_q;   // duplicate-triggered ACK, not yet latched
  logic             accept_q;
  logic             drop_q;
  logic             dllp_valid_q;
  logic [1:0]       dllp_type_q;
  logic [SEQ_W-1:0] dllp_seq_q;

  logic [SEQ_W-1:0] dist_c;
  logic             in_order_c;
  logic             dup_c;
  logic             nak_new_c;
  logic             ack_cond_c;
  logic             due_c;
  logic             latch_c;
  logic             hshk_c;

  // TLP classification and DLLP scheduling decisions
  always_comb begin
    dist_c     = nrs_q - tlp_seq_i;
    in_order_c = 1'b0;
    dup_c      = 1'b0;
    nak_new_c  = 1'b0;
    ack_cond_c = 1'b0;
    due_c      = 1'b0;
    latch_c    = 1'b0;
    hshk_c     = 1'b0;

    in_order_c = tlp_valid_i && tlp_crc_ok_i && (dist_c == '0);
    // Behind next_rcv_seq by up to half the sequence space: already received
    dup_c      = tlp_valid_i && tlp_crc_ok_i && (dist_c != '0) && (dist_c <= DUP_WIN);
    nak_new_c  = tlp_valid_i && !in_order_c && !dup_c && !nak_sched_q;

`ifdef ACK_COALESCE_EN
    ack_cond_c = (pend_q != '0) && ((tmr_q == TMR_LAST) || (pend_q >= CNT_SAT));
`else
    // Timer only runs while something is pending, so this reduces to pend != 0
    ack_cond_c = (pend_q != '0) || (tmr_q == TMR_LAST);
`endif

    due_c   = nak_flag_q || ack_flag_q || ack_cond_c;
    hshk_c  = (state_q == ST_SEND) && dllp_ready_i;
    latch_c = due_c && ((state_q != ST_SEND) || dllp_ready_i);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      nrs_q        <= '0;
      pend_q       <= '0;
      tmr_q        <= '0;
      nak_sched_q  <= 1'b0;
      nak_flag_q   <= 1'b0;
      ack_flag_q   <= 1'b0;
      accept_q     <= 1'b0;
      drop_q       <= 1'b0;
      dllp_valid_q <= 1'b0;
      dllp_type_q  <= DLLP_IDLE;
      dllp_seq_q   <= '1;
    end else begin
      accept_q <= in_order_c;
      drop_q   <= tlp_valid_i && !in_order_c;

      if (in_order_c) begin
        nrs_q <= nrs_q + SEQ_W'(1);
      end

      if (nak_new_c) begin
        nak_sched_q <= 1'b1;
      end else if (in_order_c) begin
        nak_sched_q <= 1'b0;
      end

      // A request raised in the latch cycle survives for the next DLLP
      nak_flag_q <= nak_new_c || (nak_flag_q && !latch_c);
      ack_flag_q <= dup_c || (ack_flag_q && !latch_c);

      // Latching covers everything before nrs_q; a same-cycle accept stays pending
      if (latch_c) begin
        pend_q <= in_order_c ? CNT_W'(1) : '0;
      end else if (in_order_c && (pend_q != CNT_SAT)) begin
        pend_q <= pend_q + CNT_W'(1);
      end

      if (latch_c || (pend_q == '0)) begin
        tmr_q <= '0;
      end else if (tmr_q != TMR_LAST) begin
        tmr_q <= tmr_q + TMR_W'(1);
      end

      if (latch_c) begin
        dllp_valid_q <= 1'b1;
        dllp_type_q  <= nak_flag_q ? DLLP_NAK : DLLP_ACK;
        dllp_seq_q   <= nrs_q - SEQ_W'(1);
      end else if (hshk_c) begin
        dllp_valid_q <= 1'b0;
        dllp_type_q  <= DLLP_IDLE;
      end

      case (state_q)
        ST_IDLE, ST_PEND: begin
          if (latch_c) begin
            state_q <= ST_SEND;
          end else if (in_order_c || (pend_q != '0)) begin
            state_q <= ST_PEND;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SEND: begin
          if (latch_c) begin
            state_q <= ST_SEND;
          end else if (!dllp_ready_i) begin
            state_q <= ST_SEND;
          end else if (in_order_c || (pend_q != '0)) begin
            state_q <= ST_PEND;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tlp_accept_o    = accept_q;
  assign tlp_drop_o      = drop_q;
  assign dllp_valid_o    = dllp_valid_q;
  assign dllp_type_o     = dllp_type_q;
  assign dllp_seq_o      = dllp_seq_q;
  assign nak_scheduled_o = nak_sched_q;

endmodule
